// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and default widths for the execute stage
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_AW    = 5;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/mul_seq.sv
// rtl/mul_seq.sv - iterative shift-add multiplier, one multiplier bit per clock, LSB first
module mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  logic                 run_q;
  logic [SHW-1:0]       cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     mplier_q;

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  // product_o is the accumulator after the current step, so the caller can register it on the final edge
  assign done_o    = run_q && (cnt_q == SHW'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
      if (done_o) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute stage: single-cycle ALU, iterative MUL, writeback and status flags
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int AW    = ALU_AW,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [AW-1:0]    dst,
  output logic             wb_we,
  output logic [AW-1:0]    wb_dst,
  output logic [WIDTH-1:0] wb_data,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy
);

  state_t               state_q;
  logic                 wb_we_q;
  logic [AW-1:0]        wb_dst_q;
  logic [WIDTH-1:0]     wb_data_q;
  logic                 flag_z_q;
  logic                 flag_c_q;
  logic [AW-1:0]        mul_dst_q;

  logic                 accept;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  logic [WIDTH-1:0]     b_val;
  logic [SHW-1:0]       shamt;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [WIDTH:0]       shl_w;
  logic [WIDTH:0]       shr_w;
  logic [WIDTH-1:0]     alu_r;
  logic                 alu_c;
  logic                 alu_we;
  logic                 alu_upd;

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_MUL);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  assign b_val = use_imm ? imm : opb;
  assign shamt = b_val[SHW-1:0];
  assign sum   = {1'b0, opa} + {1'b0, b_val};
  assign diff  = {1'b0, opa} - {1'b0, b_val};
  // One guard bit on each shift catches the last bit shifted out; a zero shift leaves it 0
  assign shl_w = {1'b0, opa} << shamt;
  assign shr_w = {opa, 1'b0} >> shamt;

  always_comb begin
    alu_r   = '0;
    alu_c   = flag_c_q;
    alu_we  = 1'b0;
    alu_upd = 1'b0;
    case (op)
      OP_MOV: begin alu_r = b_val;            alu_we = 1'b1; alu_upd = 1'b1; end
      OP_ADD: begin alu_r = sum[WIDTH-1:0];   alu_c = sum[WIDTH];  alu_we = 1'b1; alu_upd = 1'b1; end
      OP_SUB: begin alu_r = diff[WIDTH-1:0];  alu_c = diff[WIDTH]; alu_we = 1'b1; alu_upd = 1'b1; end
      OP_AND: begin alu_r = opa & b_val;      alu_c = 1'b0; alu_we = 1'b1; alu_upd = 1'b1; end
      OP_OR:  begin alu_r = opa | b_val;      alu_c = 1'b0; alu_we = 1'b1; alu_upd = 1'b1; end
      OP_XOR: begin alu_r = opa ^ b_val;      alu_c = 1'b0; alu_we = 1'b1; alu_upd = 1'b1; end
      OP_SHL: begin alu_r = shl_w[WIDTH-1:0]; alu_c = shl_w[WIDTH]; alu_we = 1'b1; alu_upd = 1'b1; end
      OP_SHR: begin alu_r = shr_w[WIDTH:1];   alu_c = shr_w[0];     alu_we = 1'b1; alu_upd = 1'b1; end
      OP_CMP: begin alu_r = diff[WIDTH-1:0];  alu_c = diff[WIDTH];  alu_upd = 1'b1; end
      default: begin end
    endcase
  end

  mul_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (opa),
    .b_i       (b_val),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wb_we_q   <= 1'b0;
      wb_dst_q  <= '0;
      wb_data_q <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      mul_dst_q <= '0;
    end else begin
      wb_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state_q   <= ST_MUL;
              mul_dst_q <= dst;
            end else begin
              if (alu_upd) begin
                flag_z_q <= (alu_r == '0);
                flag_c_q <= alu_c;
              end
              if (alu_we) begin
                wb_we_q   <= 1'b1;
                wb_dst_q  <= dst;
                wb_data_q <= alu_r;
              end
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state_q   <= ST_IDLE;
            wb_we_q   <= 1'b1;
            wb_dst_q  <= mul_dst_q;
            wb_data_q <= mul_prod[WIDTH-1:0];
            flag_z_q  <= (mul_prod[WIDTH-1:0] == '0);
            flag_c_q  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_dst  = wb_dst_q;
  assign wb_data = wb_data_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;

endmodule
